// File: rtl/dot_acc.sv
// Dot-product accumulator: sums a stream of unsigned products into frames closed
// by a term limit or an early last flag, and presents each frame sum on a registered output.
module dot_acc #(
  parameter int unsigned PROD_W  = 16,
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned ACC_W   = 24,
  localparam int unsigned CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  if ((N_TERMS < 1) || (ACC_W < PROD_W + $clog2(N_TERMS + 1))) begin : g_bad_params
    $error("dot_acc: ACC_W must be >= PROD_W + clog2(N_TERMS+1) and N_TERMS >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic [ACC_W-1:0]   r_out_sum;
  logic [ACC_W-1:0]   w_out_sum_nxt;
  logic [CNT_W-1:0]   r_out_count;
  logic [CNT_W-1:0]   w_out_count_nxt;

  logic               w_in_xfer;
  logic [ACC_W-1:0]   w_acc_add;
  logic [CNT_W-1:0]   w_cnt_add;
  logic               w_close;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

  // A frame starts from zero in IDLE, so the same adder serves both accepting states.
  assign w_in_xfer = in_valid && in_ready;
  assign w_acc_add = ((r_state == S_IDLE) ? '0 : r_acc) + ACC_W'(in_prod);
  assign w_cnt_add = ((r_state == S_IDLE) ? '0 : r_cnt) + CNT_W'(1);
  assign w_close   = in_last || (w_cnt_add == CNT_W'(N_TERMS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_count <= w_out_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_sum_nxt   = r_out_sum;
    w_out_count_nxt = r_out_count;

    unique case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_in_xfer) begin
          w_acc_nxt = w_acc_add;
          w_cnt_nxt = w_cnt_add;
          if (w_close) begin
            w_state_nxt     = S_HOLD;
            w_out_valid_nxt = 1'b1;
            w_out_sum_nxt   = w_acc_add;
            w_out_count_nxt = w_cnt_add;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_acc_nxt       = '0;
          w_cnt_nxt       = '0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
      end
    endcase
  end

endmodule
